// File: rtl/aes_if.sv
// rtl/aes_if.sv - Block, key and result bundle between the aes core and its source/consumer
interface aes_if #(
  parameter int Nk = 4,
  parameter int Nr = 10
);
  logic [127:0]          in;
  logic [32*Nk-1:0]      key;
  logic [128*(Nr+1)-1:0] round_keys;
  logic [127:0]          encryption_out;
  logic [127:0]          decryption_out;
  logic                  encryption_done;
  logic                  decryption_done;

  modport master (
    output in, key,
    input  round_keys, encryption_out, decryption_out, encryption_done, decryption_done
  );

  modport slave (
    input  in, key,
    output round_keys, encryption_out, decryption_out, encryption_done, decryption_done
  );
endinterface

// File: rtl/aes.sv
// rtl/aes.sv - Iterative AES core, one round per clock: encrypts the block, then decrypts
// its own ciphertext as a round-trip self-check.
module aes #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input logic  clk,
  input logic  reset_n,
  aes_if.slave bus
);
  localparam int Nb = 4;
  localparam int W  = 32*Nb*(Nr+1);
  localparam logic [1:0]  ENC = 2'd0, DEC = 2'd1, DONE = 2'd2;
  localparam logic [4:0]  LAST = 5'(Nr);
  localparam logic [31:0] MIX_FWD = 32'h02030101, MIX_INV = 32'h0e0b0d09;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Tables are expressed as inverse + affine map; every use has an 8-bit input so each folds to a ROM.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    t = ginv(a);
    return t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [W-1:0] expand(input logic [32*Nk-1:0] k);
    logic [31:0]  w [4*(Nr+1)];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [W-1:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4*(Nr+1); i++) begin
      if (i < Nk) begin
        t = k[32*Nk-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = sub_word(t);
        end
        t = w[i-Nk] ^ t;
      end
      w[i] = t;
      r[W-1-32*i -: 32] = t;
    end
    return r;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv ? inv_sbox(s[127-8*n -: 8]) : sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r (right when inverting).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*(inv ? (c-r+4)%4 : (c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic [31:0] m);
    logic [31:0] o;
    for (int r = 0; r < 4; r++) begin
      o[31-8*r -: 8] = 8'h00;
      for (int j = 0; j < 4; j++)
        o[31-8*r -: 8] = o[31-8*r -: 8] ^ gmul(c[31-8*j -: 8], m[31-8*((j-r+4)%4) -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic [31:0] m);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32], m);
    return o;
  endfunction

  logic [W-1:0]   rks;
  logic [1:0]     fsm_q, fsm_d;
  logic [4:0]     round_q, round_d;
  logic [127:0]   state_q, state_d, enc_q, enc_d, dec_q, dec_d;
  logic           enc_done_q, enc_done_d, dec_done_q, dec_done_d;
  logic [127:0]   rk_fwd, rk_inv, enc_sr, dec_sr;

  assign rks    = expand(bus.key);
  assign rk_fwd = rks[W-1-128*int'(round_q) -: 128];
  assign rk_inv = rks[W-1-128*(Nr-int'(round_q)) -: 128];
  assign enc_sr = shift_rows(sub_bytes(state_q, 1'b0), 1'b0);
  assign dec_sr = sub_bytes(shift_rows(state_q, 1'b1), 1'b1);

  always_comb begin
    fsm_d      = fsm_q;
    round_d    = round_q;
    state_d    = state_q;
    enc_d      = enc_q;
    dec_d      = dec_q;
    enc_done_d = enc_done_q;
    dec_done_d = dec_done_q;
    case (fsm_q)
      ENC: begin
        round_d = round_q + 5'd1;
        if (round_q == 5'd0) begin
          state_d = bus.in ^ rk_fwd;
        end else if (round_q != LAST) begin
          state_d = mix_columns(enc_sr, MIX_FWD) ^ rk_fwd;
        end else begin
          enc_d      = enc_sr ^ rk_fwd;
          enc_done_d = 1'b1;
          fsm_d      = DEC;
          round_d    = 5'd0;
        end
      end
      DEC: begin
        round_d = round_q + 5'd1;
        if (round_q == 5'd0) begin
          state_d = enc_q ^ rk_inv;
        end else if (round_q != LAST) begin
          state_d = mix_columns(dec_sr ^ rk_inv, MIX_INV);
        end else begin
          dec_d      = dec_sr ^ rk_inv;
          dec_done_d = 1'b1;
          fsm_d      = DONE;
          round_d    = 5'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= ENC;
      round_q    <= 5'd0;
      state_q    <= '0;
      enc_q      <= '0;
      dec_q      <= '0;
      enc_done_q <= 1'b0;
      dec_done_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      round_q    <= round_d;
      state_q    <= state_d;
      enc_q      <= enc_d;
      dec_q      <= dec_d;
      enc_done_q <= enc_done_d;
      dec_done_q <= dec_done_d;
    end
  end

  assign bus.round_keys      = rks;
  assign bus.encryption_out  = enc_q;
  assign bus.decryption_out  = dec_q;
  assign bus.encryption_done = enc_done_q;
  assign bus.decryption_done = dec_done_q;
endmodule

// File: tb/tb_aes.sv
// tb/tb_aes.sv - Scoreboard bench for the aes core with 128/192/256-bit keys
module tb_aes;
  typedef struct {
    bit           is_dec;
    logic [127:0] val;
    int           cyc;
  } exp_t;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] RK10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] T3_KEY = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] T3_PT  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] T3_CT  = 128'h29c3505f571420f6402299b31a02d73a;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  int   cyc = 0, checks = 0, errors = 0;
  exp_t qa[$], qb[$], qc[$];
  exp_t a_e, b_e, c_e;
  bit   a_have, b_have, c_have;
  bit   a_ep = 1'b0, a_dp = 1'b0, b_ep = 1'b0, b_dp = 1'b0, c_ep = 1'b0, c_dp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_if #(.Nk(4), .Nr(10)) a_if ();
  aes_if #(.Nk(6), .Nr(12)) b_if ();
  aes_if #(.Nk(8), .Nr(14)) c_if ();
  aes #(.Nk(4), .Nr(10)) dut_a (.clk(clk), .reset_n(rst_a), .bus(a_if));
  aes #(.Nk(6), .Nr(12)) dut_b (.clk(clk), .reset_n(rst_b), .bus(b_if));
  aes #(.Nk(8), .Nr(14)) dut_c (.clk(clk), .reset_n(rst_c), .bus(c_if));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic sb_cmp(input string nm, input bit have, input exp_t e, input bit is_dec,
                        input logic [127:0] act);
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected done got %h want none", nm, act);
    end else begin
      chk(is_dec ? {nm, "_dec"} : {nm, "_enc"}, act, e.val);
      chk({nm, "_kind"}, 128'(is_dec), 128'(e.is_dec));
      chk({nm, "_cycle"}, 128'(cyc), 128'(e.cyc));
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_drain"}, 128'(qa.size() + qb.size() + qc.size()), 128'h0);
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  always @(negedge clk) begin
    if ((a_if.encryption_done && !a_ep) || (a_if.decryption_done && !a_dp)) begin
      a_have = qa.size() != 0;
      if (a_have) a_e = qa.pop_front();
      sb_cmp("a", a_have, a_e, a_if.decryption_done && !a_dp,
             (a_if.decryption_done && !a_dp) ? a_if.decryption_out : a_if.encryption_out);
    end
    a_ep <= a_if.encryption_done;
    a_dp <= a_if.decryption_done;
  end

  always @(negedge clk) begin
    if ((b_if.encryption_done && !b_ep) || (b_if.decryption_done && !b_dp)) begin
      b_have = qb.size() != 0;
      if (b_have) b_e = qb.pop_front();
      sb_cmp("b", b_have, b_e, b_if.decryption_done && !b_dp,
             (b_if.decryption_done && !b_dp) ? b_if.decryption_out : b_if.encryption_out);
    end
    b_ep <= b_if.encryption_done;
    b_dp <= b_if.decryption_done;
  end

  always @(negedge clk) begin
    if ((c_if.encryption_done && !c_ep) || (c_if.decryption_done && !c_dp)) begin
      c_have = qc.size() != 0;
      if (c_have) c_e = qc.pop_front();
      sb_cmp("c", c_have, c_e, c_if.decryption_done && !c_dp,
             (c_if.decryption_done && !c_dp) ? c_if.decryption_out : c_if.encryption_out);
    end
    c_ep <= c_if.encryption_done;
    c_dp <= c_if.decryption_done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    a_if.key = KEY128; a_if.in = PT;
    b_if.key = KEY192; b_if.in = PT;
    c_if.key = KEY256; c_if.in = PT;
    #1;
    chk("t1_rk0", a_if.round_keys[1407 -: 128], KEY128);
    chk("t1_rk1", a_if.round_keys[1279 -: 128], RK1);
    chk("t1_rk10", a_if.round_keys[127:0], RK10);
    chk("reset_enc_out", a_if.encryption_out, 128'h0);
    chk("reset_dec_out", a_if.decryption_out, 128'h0);
    chk("reset_flags", 128'({a_if.encryption_done, a_if.decryption_done}), 128'h0);

    // T2, T4, T5 run side by side; in is scrambled right after edge 0.
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    qa.push_back('{1'b0, CT128, cyc + 11}); qa.push_back('{1'b1, PT, cyc + 22});
    qb.push_back('{1'b0, CT192, cyc + 13}); qb.push_back('{1'b1, PT, cyc + 26});
    qc.push_back('{1'b0, CT256, cyc + 15}); qc.push_back('{1'b1, PT, cyc + 30});
    @(posedge clk);
    #1;
    a_if.in = ~PT; b_if.in = ~PT; c_if.in = ~PT;
    wait_drain("t2_t4_t5", 80);

    repeat (4) @(posedge clk);
    #1;
    chk("hold_enc", a_if.encryption_out, CT128);
    chk("hold_dec", a_if.decryption_out, PT);
    chk("hold_flags", 128'({a_if.encryption_done, a_if.decryption_done}), 128'h3);

    // Abort during the decrypt phase: outputs must clear without a clock edge.
    @(negedge clk);
    rst_a = 1'b0;
    a_if.in = PT;
    @(negedge clk);
    rst_a = 1'b1;
    qa.push_back('{1'b0, CT128, cyc + 11});
    wait_drain("dec_abort_enc", 30);
    repeat (3) @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("dec_abort_enc_out", a_if.encryption_out, 128'h0);
    chk("dec_abort_flags", 128'({a_if.encryption_done, a_if.decryption_done}), 128'h0);

    // T6: abort at ENC edge 5, then the full T2 run must repeat with identical timing.
    @(negedge clk);
    rst_a = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("t6_enc_out", a_if.encryption_out, 128'h0);
    chk("t6_dec_out", a_if.decryption_out, 128'h0);
    chk("t6_flags", 128'({a_if.encryption_done, a_if.decryption_done}), 128'h0);
    @(negedge clk);
    rst_a = 1'b1;
    qa.push_back('{1'b0, CT128, cyc + 11}); qa.push_back('{1'b1, PT, cyc + 22});
    wait_drain("t6_rerun", 40);

    // T3: new key and block after a reset pulse.
    @(negedge clk);
    rst_a = 1'b0;
    a_if.key = T3_KEY;
    a_if.in  = T3_PT;
    @(negedge clk);
    rst_a = 1'b1;
    qa.push_back('{1'b0, T3_CT, cyc + 11}); qa.push_back('{1'b1, T3_PT, cyc + 22});
    wait_drain("t3", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
